spi_sclk_engine: RTL and testbench
==================================

# spi_sclk_engine

Parametrised SPI serial-clock engine, successor to the fixed 32-bit clock generator. It generates SCLK for a programmable number of bits per transfer and supports all four CPOL/CPHA modes. It issues one-cycle launch/capture strobes to the shift register and reports transfer completion. It sits between the Wishbone register block, which supplies configuration and `go`, and the SPI shift register.

## Interface
Parameters:
- `DIV_W`, default 16: width of the half-period divider.
- `CNT_W`, default 7: width of the bit count; maximum transfer is 2^CNT_W−1 bits.

Ports:
- `wb_clk` input, 1 bit: the only clock.
- `wb_reset_n` input, 1 bit: reset, asynchronous, active-low.
- `go` input, 1 bit: start request, sampled in IDLE only.
- `abort` input, 1 bit: terminate the transfer immediately.
- `divider` input, DIV_W bits: half period is divider+1 `wb_clk` cycles.
- `nbits` input, CNT_W bits: bits per transfer.
- `cpol` input, 1 bit: SCLK idle level.
- `cpha` input, 1 bit: clock phase.
- `sclk` output, 1 bit: serial clock, registered.
- `tip` output, 1 bit: transfer in progress.
- `launch` output, 1 bit: one-cycle strobe; drive the next bit onto MOSI.
- `capture` output, 1 bit: one-cycle strobe; sample MISO.
- `done` output, 1 bit: one-cycle strobe at normal completion.

## Operation
- States: IDLE, RUN and HOLD.
- IDLE:
  - `sclk` follows `cpol`, registered; `tip`=0.
  - `go`=1 with `nbits`≠0 → RUN. On that edge, `divider`, `nbits`, `cpol` and `cpha` are latched into shadow registers; the divider counter and edge counter are cleared.
  - `go` with `nbits`=0 is ignored.
- RUN:
  - The divider counter increments every cycle.
  - When the counter equals the shadow divider: `sclk` toggles, the counter clears, and the edge counter (CNT_W+1 bits) increments.
  - Edges are numbered 1…2·nbits. Odd edges are leading (away from idle); even edges are trailing.
  - CPHA=0: `capture` on every leading edge. `launch` on every trailing edge except edge 2·nbits. An extra `launch` fires in the cycle after the `go` edge, for the first bit.
  - CPHA=1: `launch` on leading edges, `capture` on trailing edges.
  - After edge 2·nbits (`sclk` back at `cpol`) → HOLD with the counter cleared.
- HOLD: waits one further half period (divider+1 cycles) for MISO/CS hold, then → IDLE. `done` pulses and `tip` falls on the same edge.
- `abort` in RUN or HOLD: on the next edge → IDLE, `sclk`←shadow `cpol`, `tip`←0, no strobes, no `done`. `abort` in IDLE has no effect. `abort` has priority over every other event in the same cycle.
- `go` while `tip`=1 is ignored. Configuration-input changes during a transfer are ignored (shadow registers).
- Divider arithmetic: equality compare only, no `divider`+1 addition, so there is no overflow for `divider`=all-ones. `divider`=0 gives SCLK = `wb_clk`/2.

## Timing
- Reset values: `sclk`=0, `tip`=0, `launch`=0, `capture`=0, `done`=0, state IDLE, shadow registers 0.
- An asynchronous reset mid-transfer forces these values immediately. After release, `sclk` tracks `cpol` from the first clock edge.
- Let T0 = the edge that samples `go`:
  - `tip`=1 from T0.
  - Edge k toggles `sclk` at T0+k·(d+1), where d = latched divider.
  - `done` is high for the one cycle after T0+(2n+1)·(d+1); `tip`=0 from that same edge.
- Strobes are registered and asserted in the cycle following the edge that toggles `sclk`. They are therefore coincident with the new `sclk` level.
- Back-to-back transfers: `go` sampled in the cycle `done` is high starts the next transfer. Minimum gap between transfers is one cycle.

## Structure
- Package `spi_pkg` holds:
  - state encoding localparams (IDLE/RUN/HOLD);
  - mode constants (CPOL/CPHA bit positions shared with the register block);
  - default DIV_W and CNT_W.
- One sub-module, `spi_clkdiv`, is natural. It is a DIV_W-bit prescaler with a synchronous clear that emits a `tick` when count == divider. The engine FSM, edge counter and strobe logic stay in the top module.

## Test plan
- Mode 0, divider=1, nbits=2, go at T0:
  - `sclk` edges at T0+2/4/6/8;
  - `launch` at T0+1 and T0+5;
  - `capture` at T0+3 and T0+7;
  - `done` at T0+11; `sclk` idles 0.
- Mode 3 (cpol=1, cpha=1), divider=0, nbits=3:
  - `sclk` toggles each cycle T0+1…T0+6, idle 1;
  - `launch` after edges 1/3/5, `capture` after edges 2/4/6;
  - `done` 7 cycles after T0.
- Abort after edge 3 of an 8-bit mode-1 transfer: next cycle `sclk`=0, `tip`=0; no `done`, no further strobes.
- During a transfer, change `divider` 1→5 and `cpol`, and pulse `go`: edge spacing, `sclk` polarity and edge count are unchanged, and no second transfer starts.
- DIV_W=4, divider=15, nbits=1: half period is 16 cycles with no wrap error; `go` with nbits=0 leaves `tip` low.
- Assert `wb_reset_n` low mid-RUN: all outputs 0 asynchronously. After release with cpol=1, `sclk`=1 on the next edge and a new transfer runs normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants for the SPI serial-clock engine and the register block that configures it.
package spi_pkg;

  localparam int unsigned DefaultDivW = 16;
  localparam int unsigned DefaultCntW = 7;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  // Mode field layout, shared with the control register.
  localparam int unsigned ModeCphaBit = 0;
  localparam int unsigned ModeCpolBit = 1;

endpackage

// File: rtl/spi_clkdiv.sv
// Half-period prescaler: counts up and emits tick when the count equals the divider.
module spi_clkdiv
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = DefaultDivW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [DIV_W-1:0] divider_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Equality compare only, so an all-ones divider cannot overflow.
  assign tick_o = (cnt_q == divider_i);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_sclk_engine.sv
// SPI serial-clock engine: programmable bit count, all four CPOL/CPHA modes,
// registered launch/capture strobes and a completion pulse.
module spi_sclk_engine
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = DefaultDivW,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             wb_clk,
  input  logic             wb_reset_n,
  input  logic             go,
  input  logic             abort,
  input  logic [DIV_W-1:0] divider,
  input  logic [CNT_W-1:0] nbits,
  input  logic             cpol,
  input  logic             cpha,
  output logic             sclk,
  output logic             tip,
  output logic             launch,
  output logic             capture,
  output logic             done
);

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] nbits_q;
  logic [1:0]       mode_q, mode_in;
  logic [CNT_W:0]   edge_q, edge_d, edge_num, last_edge;
  logic             sclk_q, sclk_d;
  logic             launch_q, launch_d;
  logic             capture_q, capture_d;
  logic             done_q, done_d;
  logic             load, tick, div_clear;
  logic             shadow_cpol, shadow_cpha;

  always_comb begin
    mode_in              = '0;
    mode_in[ModeCpolBit] = cpol;
    mode_in[ModeCphaBit] = cpha;
  end

  assign shadow_cpol = mode_q[ModeCpolBit];
  assign shadow_cpha = mode_q[ModeCphaBit];
  assign edge_num    = edge_q + (CNT_W+1)'(1);
  assign last_edge   = {nbits_q, 1'b0};
  assign div_clear   = (state_q == StIdle) || abort;

  spi_clkdiv #(
    .DIV_W (DIV_W)
  ) u_clkdiv (
    .clk_i     (wb_clk),
    .rst_ni    (wb_reset_n),
    .clear_i   (div_clear),
    .divider_i (div_q),
    .tick_o    (tick)
  );

  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    sclk_d    = sclk_q;
    launch_d  = 1'b0;
    capture_d = 1'b0;
    done_d    = 1'b0;
    load      = 1'b0;
    case (state_q)
      StIdle: begin
        sclk_d = cpol;
        if (go && (nbits != '0)) begin
          state_d  = StRun;
          edge_d   = '0;
          load     = 1'b1;
          // CPHA=0 needs the first bit on MOSI before the first leading edge.
          launch_d = ~cpha;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          sclk_d  = shadow_cpol;
        end else if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_num;
          if (edge_num[0]) begin
            launch_d  = shadow_cpha;
            capture_d = ~shadow_cpha;
          end else begin
            launch_d  = ~shadow_cpha && (edge_num != last_edge);
            capture_d = shadow_cpha;
          end
          if (edge_num == last_edge) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (abort) begin
          state_d = StIdle;
          sclk_d  = shadow_cpol;
        end else if (tick) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_reset_n) begin
    if (!wb_reset_n) begin
      state_q   <= StIdle;
      edge_q    <= '0;
      sclk_q    <= 1'b0;
      launch_q  <= 1'b0;
      capture_q <= 1'b0;
      done_q    <= 1'b0;
      div_q     <= '0;
      nbits_q   <= '0;
      mode_q    <= '0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      sclk_q    <= sclk_d;
      launch_q  <= launch_d;
      capture_q <= capture_d;
      done_q    <= done_d;
      if (load) begin
        div_q   <= divider;
        nbits_q <= nbits;
        mode_q  <= mode_in;
      end
    end
  end

  assign sclk    = sclk_q;
  assign tip     = (state_q != StIdle);
  assign launch  = launch_q;
  assign capture = capture_q;
  assign done    = done_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Scoreboard bench for spi_sclk_engine: expected output events are queued at stimulus time
// and a negedge monitor pops and compares them whenever the DUT shows activity.
module tb_spi_sclk_engine;

  logic        wb_clk = 1'b0;
  logic        wb_reset_n = 1'b0;
  logic        go = 1'b0, abort = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic [15:0] divider = '0;
  logic [6:0]  nbits = '0;
  logic        sclk, tip, launch, capture, done;

  logic        go2 = 1'b0, cpol2 = 1'b0, cpha2 = 1'b0;
  logic [3:0]  divider2 = '0;
  logic [6:0]  nbits2 = '0;
  logic        sclk2, tip2, launch2, capture2, done2;

  // ev = {tip changed, sclk changed, launch, capture, done}
  typedef struct packed {
    int unsigned cyc;
    logic [4:0]  ev;
    logic        tip;
    logic        sclk;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic        mon_en = 1'b0;
  logic        tip_prev = 1'b0, sclk_prev = 1'b0;
  int unsigned t0;

  always #5 wb_clk = ~wb_clk;

  always @(posedge wb_clk) cyc <= cyc + 1;

  spi_sclk_engine #(
    .DIV_W (16),
    .CNT_W (7)
  ) dut (
    .wb_clk     (wb_clk),
    .wb_reset_n (wb_reset_n),
    .go         (go),
    .abort      (abort),
    .divider    (divider),
    .nbits      (nbits),
    .cpol       (cpol),
    .cpha       (cpha),
    .sclk       (sclk),
    .tip        (tip),
    .launch     (launch),
    .capture    (capture),
    .done       (done)
  );

  spi_sclk_engine #(
    .DIV_W (4),
    .CNT_W (7)
  ) dut_small (
    .wb_clk     (wb_clk),
    .wb_reset_n (wb_reset_n),
    .go         (go2),
    .abort      (abort),
    .divider    (divider2),
    .nbits      (nbits2),
    .cpol       (cpol2),
    .cpha       (cpha2),
    .sclk       (sclk2),
    .tip        (tip2),
    .launch     (launch2),
    .capture    (capture2),
    .done       (done2)
  );

  function automatic exp_t mk(input int unsigned c, input logic [4:0] e, input logic t,
                              input logic s);
    exp_t x;
    x.cyc  = c;
    x.ev   = e;
    x.tip  = t;
    x.sclk = s;
    return x;
  endfunction

  // Monitor: any output activity must match the head of the expectation queue.
  always @(negedge wb_clk) begin
    logic [4:0] ev;
    exp_t       got, want;
    ev        = {tip != tip_prev, sclk != sclk_prev, launch, capture, done};
    tip_prev  = tip;
    sclk_prev = sclk;
    if (mon_en && (ev != 5'b0)) begin
      got   = mk(cyc, ev, tip, sclk);
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL unexpected_event: got cyc=%0d ev=%b tip=%b sclk=%b, none required",
                 got.cyc, got.ev, got.tip, got.sclk);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_err = n_err + 1;
          $display("FAIL scoreboard: got cyc=%0d ev=%b tip=%b sclk=%b, want cyc=%0d ev=%b tip=%b sclk=%b",
                   got.cyc, got.ev, got.tip, got.sclk, want.cyc, want.ev, want.tip, want.sclk);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp = n_cmp + 1;
    if (got !== want) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Timing formulas for a transfer started at t0, optionally cut short after stop_edge.
  task automatic expect_xfer(input int unsigned ts, input int unsigned d, input int unsigned n,
                             input logic pol, input logic pha, input int unsigned stop_edge);
    int unsigned last;
    logic        lead;
    last = (stop_edge == 0) ? 2 * n : stop_edge;
    exp_q.push_back(mk(ts, {1'b1, 1'b0, ~pha, 1'b0, 1'b0}, 1'b1, pol));
    for (int k = 1; k <= int'(last); k++) begin
      lead = k[0];
      exp_q.push_back(mk(ts + k * (d + 1),
                         {1'b0, 1'b1, pha ? lead : (~lead && (k != 2 * n)), pha ? ~lead : lead, 1'b0},
                         1'b1, pol ^ lead));
    end
    if (stop_edge == 0) begin
      exp_q.push_back(mk(ts + (2 * n + 1) * (d + 1), 5'b10001, 1'b0, pol));
    end
  endtask

  // Called at a negedge; returns at the negedge following the go edge (cyc == ts).
  task automatic start(input int unsigned d, input int unsigned n, input logic model,
                       input int unsigned stop_edge, output int unsigned ts);
    ts      = cyc + 1;
    divider = 16'(d);
    nbits   = 7'(n);
    go      = 1'b1;
    if (model) expect_xfer(ts, d, n, cpol, cpha, stop_edge);
    @(negedge wb_clk);
    go = 1'b0;
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    if (pol != cpol) exp_q.push_back(mk(cyc + 1, 5'b01000, 1'b0, pol));
    cpol = pol;
    cpha = pha;
    @(negedge wb_clk);
  endtask

  task automatic drain(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1;
    check("reset_outputs", {27'b0, sclk, tip, launch, capture, done}, 0);
    repeat (2) @(negedge wb_clk);
    wb_reset_n = 1'b1;
    @(negedge wb_clk);
    @(posedge wb_clk);
    mon_en = 1'b1;
    @(negedge wb_clk);

    // Mode 0, divider=1, nbits=2 (hand table).
    t0 = cyc + 1;
    exp_q.push_back(mk(t0 + 0,  5'b10100, 1'b1, 1'b0));
    exp_q.push_back(mk(t0 + 2,  5'b01010, 1'b1, 1'b1));
    exp_q.push_back(mk(t0 + 4,  5'b01100, 1'b1, 1'b0));
    exp_q.push_back(mk(t0 + 6,  5'b01010, 1'b1, 1'b1));
    exp_q.push_back(mk(t0 + 8,  5'b01000, 1'b1, 1'b0));
    exp_q.push_back(mk(t0 + 10, 5'b10001, 1'b0, 1'b0));
    start(1, 2, 1'b0, 0, t0);
    repeat (14) @(negedge wb_clk);
    drain("drain_mode0");

    // Mode 3, divider=0, nbits=3 (hand table).
    set_mode(1'b1, 1'b1);
    t0 = cyc + 1;
    exp_q.push_back(mk(t0 + 0, 5'b10000, 1'b1, 1'b1));
    exp_q.push_back(mk(t0 + 1, 5'b01100, 1'b1, 1'b0));
    exp_q.push_back(mk(t0 + 2, 5'b01010, 1'b1, 1'b1));
    exp_q.push_back(mk(t0 + 3, 5'b01100, 1'b1, 1'b0));
    exp_q.push_back(mk(t0 + 4, 5'b01010, 1'b1, 1'b1));
    exp_q.push_back(mk(t0 + 5, 5'b01100, 1'b1, 1'b0));
    exp_q.push_back(mk(t0 + 6, 5'b01010, 1'b1, 1'b1));
    exp_q.push_back(mk(t0 + 7, 5'b10001, 1'b0, 1'b1));
    start(0, 3, 1'b0, 0, t0);
    repeat (10) @(negedge wb_clk);
    drain("drain_mode3");

    // Mode 1, 8 bits, abort right after edge 3.
    set_mode(1'b0, 1'b1);
    start(1, 8, 1'b1, 3, t0);
    repeat (6) @(negedge wb_clk);
    abort = 1'b1;
    exp_q.push_back(mk(t0 + 7, 5'b11000, 1'b0, 1'b0));
    @(negedge wb_clk);
    abort = 1'b0;
    repeat (20) @(negedge wb_clk);
    drain("drain_abort");

    // Config changes and a stray go mid-transfer must not disturb it.
    set_mode(1'b0, 1'b0);
    start(1, 4, 1'b1, 0, t0);
    repeat (3) @(negedge wb_clk);
    divider = 16'd5;
    cpol    = 1'b1;
    go      = 1'b1;
    exp_q.push_back(mk(t0 + 19, 5'b01000, 1'b0, 1'b1));
    @(negedge wb_clk);
    go = 1'b0;
    repeat (20) @(negedge wb_clk);
    drain("drain_cfg_change");

    // DIV_W=4 instance: all-ones divider, one bit.
    divider2 = 4'd15;
    nbits2   = 7'd1;
    go2      = 1'b1;
    @(negedge wb_clk);
    go2 = 1'b0;
    for (int i = 0; i <= 52; i++) begin
      check("small_div15", {27'b0, tip2, sclk2, launch2, capture2, done2},
            {27'b0, (i < 48) ? 1'b1 : 1'b0, (i >= 16 && i < 32) ? 1'b1 : 1'b0,
             (i == 0) ? 1'b1 : 1'b0, (i == 16) ? 1'b1 : 1'b0, (i == 48) ? 1'b1 : 1'b0});
      @(negedge wb_clk);
    end
    nbits2 = 7'd0;
    go2    = 1'b1;
    @(negedge wb_clk);
    go2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("small_nbits0_tip", {31'b0, tip2}, 0);
      @(negedge wb_clk);
    end

    // Asynchronous reset mid-RUN (cpol is 1 here), then a fresh transfer.
    start(3, 4, 1'b1, 0, t0);
    repeat (2) @(negedge wb_clk);
    check("pre_reset_tip_sclk", {30'b0, tip, sclk}, 3);
    @(posedge wb_clk);
    mon_en = 1'b0;
    #2;
    wb_reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {27'b0, sclk, tip, launch, capture, done}, 0);
    exp_q.delete();
    repeat (3) @(negedge wb_clk);
    wb_reset_n = 1'b1;
    @(negedge wb_clk);
    check("post_reset_sclk_cpol", {30'b0, sclk, tip}, 2);
    @(posedge wb_clk);
    mon_en = 1'b1;
    @(negedge wb_clk);
    start(1, 2, 1'b1, 0, t0);
    repeat (14) @(negedge wb_clk);
    drain("drain_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
